// File: rtl/multicore_pkg.sv
// ============================================================================
// Module   : multicore_pkg
// Brief    : Shared core-count, sample-width and sample type definitions.
// Revision : 1.0
// ============================================================================
`default_nettype none

package multicore_pkg;

  localparam int N_CORES  = 22;
  localparam int SAMPLE_W = 31;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with registered occupancy count, head visible
//            combinationally on rdata.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == LVL_W'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage carries no reset; resetting the pointers discards its contents.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sample_dispatcher.sv
// ============================================================================
// Module   : sample_dispatcher
// Brief    : Buffers ADC samples and hands them one at a time to requesting
//            cores under round-robin arbitration.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sample_dispatcher #(
  parameter int N_CORES    = multicore_pkg::N_CORES,
  parameter int SAMPLE_W   = multicore_pkg::SAMPLE_W,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          adc_valid,
  input  logic signed [SAMPLE_W-1:0]    adc_data,
  output logic                          adc_ready,
  input  logic [N_CORES-1:0]            req_in,
  output logic signed [SAMPLE_W-1:0]    core_data,
  output logic [N_CORES-1:0]            core_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   starve_cnt
);

  localparam int                IDX_W      = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [IDX_W-1:0]  C_LAST_RST = IDX_W'(N_CORES - 1);

  logic                          w_full;
  logic                          w_empty;
  logic [SAMPLE_W-1:0]           w_head;
  logic                          w_push;
  logic                          w_grant;
  logic                          w_starve;
  logic [N_CORES-1:0]            w_req_eff;
  logic [N_CORES-1:0]            w_onehot;
  logic [IDX_W-1:0]              w_sel;
  logic [IDX_W-1:0]              w_sel_hi;
  logic [IDX_W-1:0]              w_sel_lo;
  logic                          w_found_hi;

  logic [IDX_W-1:0]              r_last;
  logic [N_CORES-1:0]            r_core_ack;
  logic signed [SAMPLE_W-1:0]    r_core_data;
  logic [15:0]                   r_starve;

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (adc_data),
    .pop   (w_grant),
    .rdata (w_head),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  assign adc_ready = !w_full;
  assign w_push    = adc_valid && adc_ready;

  // Masking with the live ack stops a held request from winning twice in a row.
  assign w_req_eff = req_in & ~r_core_ack;
  assign w_grant   = (|w_req_eff) && !w_empty && !(|r_core_ack);
  assign w_starve  = (|w_req_eff) && w_empty;

  // Lowest requester above the last winner, else lowest overall (wrap-around).
  always_comb begin
    w_found_hi = 1'b0;
    w_sel_hi   = '0;
    w_sel_lo   = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (w_req_eff[i]) begin
        w_sel_lo = IDX_W'(i);
        if (IDX_W'(i) > r_last) begin
          w_sel_hi   = IDX_W'(i);
          w_found_hi = 1'b1;
        end
      end
    end
    w_sel = w_found_hi ? w_sel_hi : w_sel_lo;
  end

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last      <= C_LAST_RST;
      r_core_ack  <= '0;
      r_core_data <= '0;
      r_starve    <= '0;
    end else begin
      r_core_ack <= '0;
      if (w_grant) begin
        r_core_ack  <= w_onehot;
        r_core_data <= w_head;
        r_last      <= w_sel;
      end
      if (w_starve && (r_starve != 16'hFFFF)) begin
        r_starve <= r_starve + 16'd1;
      end
    end
  end

  assign core_ack   = r_core_ack;
  assign core_data  = r_core_data;
  assign starve_cnt = r_starve;

endmodule

`default_nettype wire

// File: doc/sample_dispatcher.md
SAMPLE_DISPATCHER -- requirements
Module: sample_dispatcher

Interface
REQ-001 Parameter N_CORES, default 22: number of requesting cores.
REQ-002 Parameter SAMPLE_W, default 31: signed ADC sample width.
REQ-003 Parameter FIFO_DEPTH, default 16: sample buffer depth, power of two, at least 2.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 adc_valid  input  1  ADC sample offered this cycle.
REQ-007 adc_data  input  SAMPLE_W  signed ADC sample.
REQ-008 adc_ready  output  1  dispatcher accepts a sample this cycle.
REQ-009 req_in  input  N_CORES  per-core level request for one sample; held until acked.
REQ-010 core_data  output  SAMPLE_W  signed sample broadcast to all cores.
REQ-011 core_ack  output  N_CORES  one-hot; bit i marks core_data valid for core i.
REQ-012 fifo_level  output  $clog2(FIFO_DEPTH)+1  buffered sample count.
REQ-013 starve_cnt  output  16  saturating count of cycles with a pending request and an empty FIFO.

Function
REQ-014 adc_ready SHALL equal (fifo_level != FIFO_DEPTH), computed from the registered level only.
REQ-015 A push SHALL occur when adc_valid and adc_ready are both high; adc_data is written at the tail.
REQ-016 A grant SHALL occur in cycle t when req_in is nonzero, the FIFO is non-empty, and no core_ack bit is high in cycle t.
REQ-017 On a grant, in cycle t+1 the dispatcher SHALL pop the head sample to core_data (registered) and raise exactly one core_ack bit.
REQ-018 Latency from request to data SHALL be 1 cycle when the FIFO is non-empty; at most one sample is dispatched every 2 cycles.
REQ-019 Arbitration SHALL be round-robin: search starts at the core after the last granted core, wrapping from N_CORES-1 to 0; after reset the last granted core is N_CORES-1, so core 0 has first priority.
REQ-020 A core's req_in bit SHALL be ignored in the cycle its core_ack is high, so a held request cannot be granted twice back-to-back.
REQ-021 Outside ack cycles, core_ack SHALL be 0 and core_data SHALL hold its last value.
REQ-022 In a cycle with both push and pop, fifo_level SHALL be unchanged and both pointers advance.
REQ-023 When the FIFO is full and a pop occurs, adc_ready stays low that cycle (no same-cycle refill); the push is accepted the next cycle.
REQ-024 With an empty FIFO and a pending request, no grant occurs; starve_cnt increments and saturates at 16'hFFFF.
REQ-025 A sample pushed in cycle t is grantable from cycle t+1; there is no write-to-read bypass.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-027 When rst_n is low at a clock edge: pointers = 0, fifo_level = 0, core_ack = 0, core_data = 0, starve_cnt = 0, and the round-robin pointer = N_CORES-1.
REQ-028 adc_ready SHALL read 1 in the first cycle after reset.
REQ-029 Reset asserted mid-grant drops the in-flight pop: core_ack is 0 in the next cycle and all buffered samples are discarded.

Structure
REQ-030 The shared package multicore_pkg SHALL hold N_CORES, SAMPLE_W, and the sample_t signed typedef.
REQ-031 Buffering SHALL be one sub-module, sync_fifo (SAMPLE_W x FIFO_DEPTH, registered count, synchronous active-low reset).
REQ-032 The arbiter and the ack/data registers SHALL live in sample_dispatcher.

Verification
REQ-033 Reset, then push 5, -7, 12 with req_in = 0 -> fifo_level = 3, core_ack = 0, adc_ready = 1.
REQ-034 FIFO holds 5, -7, 12; req_in[3] held for 6 cycles -> core 3 is acked with 5, -7, 12 in cycles t+1, t+3, t+5; fifo_level reaches 0.
REQ-035 Cores 0, 1 and 21 request continuously with 6 samples buffered -> grant order is 0, 1, 21, 0, 1, 21, and never two acks in consecutive cycles.
REQ-036 Fill 16 samples -> adc_ready = 0; pop once -> adc_ready = 0 that cycle and 1 the next; push 99 -> fifo_level returns to 16.
REQ-037 FIFO empty, req_in[2] held 10 cycles -> starve_cnt = 10, no ack; push 42 -> core 2 is acked with 42 two cycles after the push.
REQ-038 rst_n low in the grant cycle -> core_ack = 0, fifo_level = 0, core_data = 0 the following cycle.
